// File: rtl/gerador_tom_pkg.sv
// Shared constants for the tone generator: half-period table, note codes
// and the state encoding of the playback FSM.
package tom_pkg;

  localparam int N_NOTAS = 7;

  // Half-period of each note, in 50 MHz clock cycles, C4..B4
  localparam logic [16:0] MEIO_PERIODO [N_NOTAS] = '{
    17'd95420, 17'd85034, 17'd75758, 17'd71633,
    17'd63776, 17'd56818, 17'd50607
  };

  localparam logic [2:0] NOTA_SILENCIO = 3'd0;
  localparam logic [2:0] NOTA_DO       = 3'd1;
  localparam logic [2:0] NOTA_RE       = 3'd2;
  localparam logic [2:0] NOTA_MI       = 3'd3;
  localparam logic [2:0] NOTA_FA       = 3'd4;
  localparam logic [2:0] NOTA_SOL      = 3'd5;
  localparam logic [2:0] NOTA_LA       = 3'd6;
  localparam logic [2:0] NOTA_SI       = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    TROCA = 2'd2
  } estado_t;

  // Raw table entry for a note code; silence maps to 1 so callers never see 0
  function automatic logic [16:0] meio_periodo(input logic [2:0] codigo);
    if (codigo == NOTA_SILENCIO) return 17'd1;
    return MEIO_PERIODO[codigo - 3'd1];
  endfunction

endpackage

// File: rtl/gerador_tom_if.sv
// Note-code input and playback status bundle between the game logic and
// the tone generator.
interface gerador_tom_if;
  logic       enable;
  logic [2:0] nota;
  logic       buzzer;
  logic       tocando;
  logic [2:0] nota_atual;
  logic [7:0] contador_notas;
  logic [1:0] db_estado;

  modport master (
    output enable, nota,
    input  buzzer, tocando, nota_atual, contador_notas, db_estado
  );

  modport slave (
    input  enable, nota,
    output buzzer, tocando, nota_atual, contador_notas, db_estado
  );
endinterface

// File: rtl/gerador_tom_estabilizador.sv
// Debounces the incoming note code and raises a one-cycle-qualified accept
// once the code has been stable for STABLE_CYCLES samples.
module estabilizador_codigo #(
  parameter int STABLE_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] nota,
  input  logic [2:0] nota_atual,
  output logic [2:0] codigo,
  output logic       aceite
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] SAT = CW'(STABLE_CYCLES - 1);

  logic [2:0]    cand;
  logic [CW-1:0] cont_estavel;

  always_ff @(posedge clock) begin
    if (reset) begin
      cand         <= '0;
      cont_estavel <= '0;
    end else begin
      cand <= nota;
      if (nota != cand)
        cont_estavel <= '0;
      else if (cont_estavel != SAT)
        cont_estavel <= cont_estavel + 1'b1;
    end
  end

  // Level-qualified so a code held through an enable drop restarts at once
  assign codigo = cand;
  assign aceite = (cont_estavel == SAT) && enable && (cand != nota_atual);

endmodule

// File: rtl/gerador_tom.sv
// Square-wave tone generator: debounced note code in, glitch-free buzzer out,
// note changes applied only on half-period boundaries.
//
//   state | meaning
//   IDLE  | silent, waiting for an accepted nonzero code
//   PLAY  | sounding nota_atual, half-period down-counter running
//   TROCA | still sounding nota_atual, pend applied at next terminal count
module gerador_tom
  import tom_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000,
  parameter int DIV_SHIFT     = 0,
  parameter int CNT_W         = 17
) (
  input logic         clock,
  input logic         reset,
  gerador_tom_if.slave bus
);

  estado_t          estado, estado_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             buzzer_q, buzzer_n;
  logic [2:0]       nota_atual_q, nota_atual_n;
  logic [2:0]       pend, pend_n;
  logic [7:0]       contador, contador_n;
  logic [2:0]       codigo;
  logic             aceite;
  logic             terminal;

  estabilizador_codigo #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_estab (
    .clock     (clock),
    .reset     (reset),
    .enable    (bus.enable),
    .nota      (bus.nota),
    .nota_atual(nota_atual_q),
    .codigo    (codigo),
    .aceite    (aceite)
  );

  // Reload value HP-1, with HP floored at 1 after the shift
  function automatic logic [CNT_W-1:0] recarga(input logic [2:0] c);
    logic [16:0] hp;
    hp = meio_periodo(c) >> DIV_SHIFT;
    if (hp == 17'd0) hp = 17'd1;
    return CNT_W'(hp - 17'd1);
  endfunction

  assign terminal = (cnt == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= IDLE;
      cnt          <= '0;
      buzzer_q     <= 1'b0;
      nota_atual_q <= NOTA_SILENCIO;
      pend         <= NOTA_SILENCIO;
      contador     <= '0;
    end else begin
      estado       <= estado_n;
      cnt          <= cnt_n;
      buzzer_q     <= buzzer_n;
      nota_atual_q <= nota_atual_n;
      pend         <= pend_n;
      contador     <= contador_n;
    end
  end

  always_comb begin
    estado_n     = estado;
    cnt_n        = cnt;
    buzzer_n     = buzzer_q;
    nota_atual_n = nota_atual_q;
    pend_n       = pend;
    contador_n   = contador;

    if (!bus.enable) begin
      estado_n     = IDLE;
      cnt_n        = '0;
      buzzer_n     = 1'b0;
      nota_atual_n = NOTA_SILENCIO;
      pend_n       = NOTA_SILENCIO;
    end else begin
      unique case (estado)
        IDLE: begin
          buzzer_n     = 1'b0;
          nota_atual_n = NOTA_SILENCIO;
          if (aceite && codigo != NOTA_SILENCIO) begin
            estado_n     = PLAY;
            cnt_n        = recarga(codigo);
            buzzer_n     = 1'b1;
            nota_atual_n = codigo;
            contador_n   = contador + 8'd1;
          end
        end
        PLAY: begin
          if (terminal) begin
            buzzer_n = ~buzzer_q;
            cnt_n    = recarga(nota_atual_q);
          end else begin
            cnt_n = cnt - 1'b1;
          end
          if (aceite) begin
            estado_n = TROCA;
            pend_n   = codigo;
          end
        end
        TROCA: begin
          if (terminal) begin
            if (pend != NOTA_SILENCIO) begin
              estado_n     = PLAY;
              buzzer_n     = ~buzzer_q;
              cnt_n        = recarga(pend);
              nota_atual_n = pend;
              contador_n   = contador + 8'd1;
            end else begin
              estado_n     = IDLE;
              buzzer_n     = 1'b0;
              nota_atual_n = NOTA_SILENCIO;
            end
          end else begin
            cnt_n = cnt - 1'b1;
            if (aceite) pend_n = codigo;
          end
        end
        default: estado_n = IDLE;
      endcase
    end
  end

  assign bus.buzzer         = buzzer_q;
  assign bus.tocando        = (estado == PLAY) || (estado == TROCA);
  assign bus.nota_atual     = nota_atual_q;
  assign bus.contador_notas = contador;
  assign bus.db_estado      = estado;

endmodule

// File: tb/tb_gerador_tom.sv
// Directed vector bench for gerador_tom with STABLE_CYCLES=4, DIV_SHIFT=10
// (half-periods C=93, D=83, E=73, A=55, B=49).
module tb_gerador_tom;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  gerador_tom_if bus ();

  gerador_tom #(
    .STABLE_CYCLES(4),
    .DIV_SHIFT    (10),
    .CNT_W        (17)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       en;
    logic [2:0] nota;
    int         ncyc;
    logic       buz;
    logic       toc;
    logic [2:0] na;
    logic [7:0] cont;
    logic [1:0] est;
  } vec_t;

  vec_t vecs [31];

  function automatic logic [14:0] observado();
    return {bus.buzzer, bus.tocando, bus.nota_atual, bus.contador_notas, bus.db_estado};
  endfunction

  task automatic verifica(input string nome, input logic [14:0] exp);
    logic [14:0] got;
    got = observado();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got buz=%b toc=%b na=%0d cont=%0d est=%0d, expected buz=%b toc=%b na=%0d cont=%0d est=%0d",
               nome, got[14], got[13], got[12:10], got[9:2], got[1:0],
               exp[14], exp[13], exp[12:10], exp[9:2], exp[1:0]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs = '{
      '{1'b1, 3'd0,  0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd0},  // reset state
      '{1'b1, 3'd1,  3, 1'b0, 1'b0, 3'd0, 8'd0, 2'd0},  // glitch 3 cycles
      '{1'b1, 3'd0,  6, 1'b0, 1'b0, 3'd0, 8'd0, 2'd0},
      '{1'b1, 3'd1,  4, 1'b0, 1'b0, 3'd0, 8'd0, 2'd0},  // not yet accepted
      '{1'b1, 3'd1,  1, 1'b1, 1'b1, 3'd1, 8'd1, 2'd1},  // accepted edge k+4
      '{1'b0, 3'd1,  1, 1'b0, 1'b0, 3'd0, 8'd1, 2'd0},  // enable drop
      '{1'b1, 3'd1,  1, 1'b1, 1'b1, 3'd1, 8'd2, 2'd1},  // immediate restart
      '{1'b1, 3'd1, 92, 1'b1, 1'b1, 3'd1, 8'd2, 2'd1},  // C level 92 edges in
      '{1'b1, 3'd1,  1, 1'b0, 1'b1, 3'd1, 8'd2, 2'd1},  // toggles at 93
      '{1'b1, 3'd6,  4, 1'b0, 1'b1, 3'd1, 8'd2, 2'd1},
      '{1'b1, 3'd6,  1, 1'b0, 1'b1, 3'd1, 8'd2, 2'd2},  // TROCA
      '{1'b1, 3'd6, 87, 1'b0, 1'b1, 3'd1, 8'd2, 2'd2},  // C level still running
      '{1'b1, 3'd6,  1, 1'b1, 1'b1, 3'd6, 8'd3, 2'd1},  // switch to A
      '{1'b1, 3'd0,  4, 1'b1, 1'b1, 3'd6, 8'd3, 2'd1},
      '{1'b1, 3'd0,  1, 1'b1, 1'b1, 3'd6, 8'd3, 2'd2},
      '{1'b1, 3'd0, 49, 1'b1, 1'b1, 3'd6, 8'd3, 2'd2},  // A level 54 edges in
      '{1'b1, 3'd0,  1, 1'b0, 1'b0, 3'd0, 8'd3, 2'd0},  // stop at 55
      '{1'b1, 3'd0,  5, 1'b0, 1'b0, 3'd0, 8'd3, 2'd0},
      '{1'b1, 3'd7,  4, 1'b0, 1'b0, 3'd0, 8'd3, 2'd0},
      '{1'b1, 3'd7,  1, 1'b1, 1'b1, 3'd7, 8'd4, 2'd1},  // B starts
      '{1'b1, 3'd7, 10, 1'b1, 1'b1, 3'd7, 8'd4, 2'd1},
      '{1'b0, 3'd7,  1, 1'b0, 1'b0, 3'd0, 8'd4, 2'd0},
      '{1'b1, 3'd7,  1, 1'b1, 1'b1, 3'd7, 8'd5, 2'd1},
      '{1'b1, 3'd2,  4, 1'b1, 1'b1, 3'd7, 8'd5, 2'd1},
      '{1'b1, 3'd2,  1, 1'b1, 1'b1, 3'd7, 8'd5, 2'd2},  // pend=2
      '{1'b1, 3'd3,  4, 1'b1, 1'b1, 3'd7, 8'd5, 2'd2},
      '{1'b1, 3'd3,  1, 1'b1, 1'b1, 3'd7, 8'd5, 2'd2},  // pend=3 overwrites
      '{1'b1, 3'd3, 38, 1'b1, 1'b1, 3'd7, 8'd5, 2'd2},  // B level 48 edges in
      '{1'b1, 3'd3,  1, 1'b0, 1'b1, 3'd3, 8'd6, 2'd1},  // E takes over, +1 only
      '{1'b1, 3'd3, 72, 1'b0, 1'b1, 3'd3, 8'd6, 2'd1},
      '{1'b1, 3'd3,  1, 1'b1, 1'b1, 3'd3, 8'd6, 2'd1}   // E level is 73
    };

    reset      = 1'b1;
    bus.enable = 1'b1;
    bus.nota   = 3'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 31; i++) begin
      bus.enable = vecs[i].en;
      bus.nota   = vecs[i].nota;
      if (vecs[i].ncyc > 0) begin
        repeat (vecs[i].ncyc) @(posedge clock);
        @(negedge clock);
      end
      verifica($sformatf("vec%0d", i),
               {vecs[i].buz, vecs[i].toc, vecs[i].na, vecs[i].cont, vecs[i].est});
    end

    // Counter wrap: enable pulses restart E immediately, +1 per restart
    for (int n = 0; n < 250; n++) begin
      bus.enable = 1'b0;
      @(posedge clock);
      @(negedge clock);
      bus.enable = 1'b1;
      @(posedge clock);
      @(negedge clock);
      if (n == 248) verifica("cont_255", {1'b1, 1'b1, 3'd3, 8'd255, 2'd1});
    end
    verifica("cont_wrap", {1'b1, 1'b1, 3'd3, 8'd0, 2'd1});

    // Reset mid-note wins over enable and clears the debouncer too
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    verifica("reset_mid", {1'b0, 1'b0, 3'd0, 8'd0, 2'd0});
    reset = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    verifica("post_reset_wait", {1'b0, 1'b0, 3'd0, 8'd0, 2'd0});
    @(posedge clock);
    @(negedge clock);
    verifica("post_reset_start", {1'b1, 1'b1, 3'd3, 8'd1, 2'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
